// File: rtl/core_rf_pkg.sv
// Shared defaults, FSM state encoding and the hard-wired zero register address
// for the ID-stage register file with load scoreboard.
package core_rf_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NUM_RD_DEF = 2;

    localparam int ZERO_REG = 0;

    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2
    } rf_state_e;

endpackage

// File: rtl/core_rf_rd_port.sv
// One combinational read port: zero register, write-back bypass (port 0 over port 1)
// and the post-edge view of the pending bit.
module core_rf_rd_port
    import core_rf_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              active,
    input  logic [ADDR_W-1:0] raddr,
    input  logic              wen0,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              wen1,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              set_pend,
    input  logic [ADDR_W-1:0] pend_addr,
    input  logic [DATA_W-1:0] arr_data,
    input  logic              arr_pend,
    output logic [DATA_W-1:0] rdata,
    output logic              rbusy
);

    logic is_zero;
    logic hit0;
    logic hit1;
    logic hitp;

    assign is_zero = (raddr == ADDR_W'(ZERO_REG));
    assign hit0    = wen0 && (waddr0 == raddr);
    assign hit1    = wen1 && (waddr1 == raddr);
    assign hitp    = set_pend && (pend_addr == raddr);

    always_comb begin
        rdata = '0;
        rbusy = 1'b0;
        if (active && !is_zero) begin
            if (hit0) begin
                rdata = wdata0;
            end else if (hit1) begin
                rdata = wdata1;
            end else begin
                rdata = arr_data;
            end
            // a same-cycle set beats the clear from any write
            if (hitp) begin
                rbusy = 1'b1;
            end else if (hit0 || hit1) begin
                rbusy = 1'b0;
            end else begin
                rbusy = arr_pend;
            end
        end
    end

endmodule

// File: rtl/core_id_regfile_sb.sv
// ID-stage register file: NUM_RD bypassed read ports, write-back and load-return
// write ports, per-register pending bits, and a hardware zeroing sweep after reset.
//
// state | meaning
// RST   | reset asserted, sweep counter held at 0, all ports inert
// INIT  | zeroing reg[cnt] and pend[cnt] one index per cycle
// RUN   | normal operation, init_done high
module core_id_regfile_sb
    import core_rf_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = NUM_RD_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     init_done,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic [NUM_RD-1:0]        rbusy,
    input  logic                     wen0,
    input  logic [ADDR_W-1:0]        waddr0,
    input  logic [DATA_W-1:0]        wdata0,
    input  logic                     wen1,
    input  logic [ADDR_W-1:0]        waddr1,
    input  logic [DATA_W-1:0]        wdata1,
    input  logic                     set_pend,
    input  logic [ADDR_W-1:0]        pend_addr
);

    localparam int DEPTH = 2 ** ADDR_W;

    rf_state_e         state_q;
    rf_state_e         state_d;
    logic [ADDR_W-1:0] cnt_q;
    logic              run;
    logic              sweep;
    logic              sweep_last;
    logic              we0;
    logic              we1;
    logic              sp;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pend_q;

    assign run        = (state_q == ST_RUN);
    assign sweep      = (state_q == ST_INIT);
    assign sweep_last = (cnt_q == ADDR_W'(DEPTH - 1));
    assign init_done  = run;

    // register 0 is never written nor marked, so its array slot stays zero
    assign we0 = run && wen0 && (waddr0 != ADDR_W'(ZERO_REG));
    assign we1 = run && wen1 && (waddr1 != ADDR_W'(ZERO_REG));
    assign sp  = run && set_pend && (pend_addr != ADDR_W'(ZERO_REG));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_RST;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (sweep) begin
                cnt_q <= cnt_q + ADDR_W'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RST:  state_d = ST_INIT;
            ST_INIT: if (sweep_last) state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_RST;
        endcase
    end

    // port 0 is written last so it wins an address collision
    always_ff @(posedge clk) begin
        if (rst) begin
            if (sweep) begin
                regs[cnt_q] <= '0;
            end else begin
                if (we1) regs[waddr1] <= wdata1;
                if (we0) regs[waddr0] <= wdata0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if (sweep) begin
                pend_q[cnt_q] <= 1'b0;
            end else begin
                if (we0) pend_q[waddr0] <= 1'b0;
                if (we1) pend_q[waddr1] <= 1'b0;
                if (sp)  pend_q[pend_addr] <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;

        assign ra = raddr[i*ADDR_W +: ADDR_W];

        core_rf_rd_port #(
            .DATA_W(DATA_W),
            .ADDR_W(ADDR_W)
        ) u_rd (
            .active   (run),
            .raddr    (ra),
            .wen0     (we0),
            .waddr0   (waddr0),
            .wdata0   (wdata0),
            .wen1     (we1),
            .waddr1   (waddr1),
            .wdata1   (wdata1),
            .set_pend (sp),
            .pend_addr(pend_addr),
            .arr_data (regs[ra]),
            .arr_pend (pend_q[ra]),
            .rdata    (rdata[i*DATA_W +: DATA_W]),
            .rbusy    (rbusy[i])
        );
    end

endmodule

// File: tb/tb_core_id_regfile_sb.sv
// Directed bench for core_id_regfile_sb: the driver queues hand-computed
// expectations each cycle, a monitor pops and compares them at the falling edge.
module tb_core_id_regfile_sb;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             init_done;
    logic [NR*AW-1:0] raddr;
    logic [NR*DW-1:0] rdata;
    logic [NR-1:0]    rbusy;
    logic             wen0;
    logic [AW-1:0]    waddr0;
    logic [DW-1:0]    wdata0;
    logic             wen1;
    logic [AW-1:0]    waddr1;
    logic [DW-1:0]    wdata1;
    logic             set_pend;
    logic [AW-1:0]    pend_addr;

    core_id_regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
        .clk      (clk),
        .rst      (rst),
        .init_done(init_done),
        .raddr    (raddr),
        .rdata    (rdata),
        .rbusy    (rbusy),
        .wen0     (wen0),
        .waddr0   (waddr0),
        .wdata0   (wdata0),
        .wen1     (wen1),
        .waddr1   (waddr1),
        .wdata1   (wdata1),
        .set_pend (set_pend),
        .pend_addr(pend_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          kind;   // 0: read port data+busy, 1: init_done
        int          port;
        logic [31:0] data;
        logic        busy;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    always begin
        exp_t e;
        @(negedge clk);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (e.kind == 1) begin
                checks++;
                if (init_done !== e.busy) begin
                    failures++;
                    $display("FAIL %s: init_done=%0b expected %0b", e.name, init_done, e.busy);
                end
            end else begin
                checks++;
                if (rdata[e.port*DW +: DW] !== e.data) begin
                    failures++;
                    $display("FAIL %s: port%0d rdata=%h expected %h", e.name, e.port,
                             rdata[e.port*DW +: DW], e.data);
                end
                checks++;
                if (rbusy[e.port] !== e.busy) begin
                    failures++;
                    $display("FAIL %s: port%0d rbusy=%0b expected %0b", e.name, e.port,
                             rbusy[e.port], e.busy);
                end
            end
        end
    end

    task automatic push_rd(input string n, input int p, input logic [31:0] d, input logic b);
        exp_t e;
        e.name = n; e.kind = 0; e.port = p; e.data = d; e.busy = b;
        exp_q.push_back(e);
    endtask

    task automatic push_init(input string n, input logic v);
        exp_t e;
        e.name = n; e.kind = 1; e.port = 0; e.data = '0; e.busy = v;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        wen0 = 1'b0; waddr0 = '0; wdata0 = '0;
        wen1 = 1'b0; waddr1 = '0; wdata1 = '0;
        set_pend = 1'b0; pend_addr = '0;
        raddr = '0;
    endtask

    // advance one edge and return to an idle input set just after it
    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic set_ra(input int p, input logic [AW-1:0] a);
        raddr[p*AW +: AW] = a;
    endtask

    // rst was driven high after the previous edge: edge 0 samples it, edges 1..32 sweep
    task automatic run_sweep(input string n);
        for (int i = 0; i < 32; i++) begin
            step();
            push_init(n, 1'b0);
            set_ra(0, 5'd1);
            push_rd({n, "_rd"}, 0, 32'h0, 1'b0);
            if (i == 10) begin
                wen0 = 1'b1; waddr0 = 5'd1; wdata0 = 32'hAAAA_5555;
            end
        end
        step();
        push_init({n, "_done"}, 1'b1);
    endtask

    initial begin
        rst = 1'b0;
        idle();

        for (int i = 0; i < 3; i++) begin
            step();
            push_init("rst_init_done", 1'b0);
            wen0 = 1'b1; waddr0 = 5'd2; wdata0 = 32'h1234_5678;
            set_pend = 1'b1; pend_addr = 5'd2;
            set_ra(0, 5'd2);
            push_rd("rst_rd", 0, 32'h0, 1'b0);
        end
        rst = 1'b1;
        run_sweep("init");

        for (int a = 0; a < 32; a++) begin
            step();
            set_ra(0, AW'(a));
            set_ra(1, AW'(31 - a));
            push_rd("zero_p0", 0, 32'h0, 1'b0);
            push_rd("zero_p1", 1, 32'h0, 1'b0);
        end

        step();
        wen0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEAD_BEEF;
        set_ra(0, 5'd5);
        push_rd("wr_bypass", 0, 32'hDEAD_BEEF, 1'b0);
        step();
        set_ra(0, 5'd5);
        push_rd("wr_array", 0, 32'hDEAD_BEEF, 1'b0);

        step();
        set_pend = 1'b1; pend_addr = 5'd7;
        set_ra(1, 5'd7);
        push_rd("pend7_set", 1, 32'h0, 1'b1);
        step();
        wen0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h11;
        wen1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h22;
        set_ra(0, 5'd7);
        set_ra(1, 5'd7);
        push_rd("coll_byp_p0", 0, 32'h11, 1'b0);
        push_rd("coll_byp_p1", 1, 32'h11, 1'b0);
        step();
        set_ra(0, 5'd7);
        set_ra(1, 5'd7);
        push_rd("coll_arr_p0", 0, 32'h11, 1'b0);
        push_rd("coll_arr_p1", 1, 32'h11, 1'b0);

        step();
        set_pend = 1'b1; pend_addr = 5'd9;
        set_ra(0, 5'd9);
        push_rd("sb_set", 0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            set_ra(0, 5'd9);
            set_ra(1, 5'd9);
            push_rd("sb_hold_p0", 0, 32'h0, 1'b1);
            push_rd("sb_hold_p1", 1, 32'h0, 1'b1);
        end
        step();
        wen1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h55;
        set_ra(1, 5'd9);
        push_rd("sb_ret", 1, 32'h55, 1'b0);
        step();
        set_ra(1, 5'd9);
        push_rd("sb_ret_arr", 1, 32'h55, 1'b0);
        step();
        set_pend = 1'b1; pend_addr = 5'd9;
        wen1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h66;
        set_ra(0, 5'd9);
        push_rd("sb_set_wins", 0, 32'h66, 1'b1);
        step();
        set_ra(0, 5'd9);
        push_rd("sb_set_wins_arr", 0, 32'h66, 1'b1);

        step();
        wen0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFFFF_FFFF;
        set_pend = 1'b1; pend_addr = 5'd0;
        push_rd("r0_byp_p0", 0, 32'h0, 1'b0);
        push_rd("r0_byp_p1", 1, 32'h0, 1'b0);
        step();
        push_rd("r0_arr", 0, 32'h0, 1'b0);

        step();
        wen0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h1234;
        set_pend = 1'b1; pend_addr = 5'd4;
        step();
        set_ra(0, 5'd3);
        set_ra(1, 5'd4);
        push_rd("pre_rst_r3", 0, 32'h1234, 1'b0);
        push_rd("pre_rst_r4", 1, 32'h0, 1'b1);
        rst = 1'b0;
        step();
        push_init("mid_rst_done", 1'b0);
        set_ra(0, 5'd3);
        push_rd("mid_rst_rd", 0, 32'h0, 1'b0);
        rst = 1'b1;
        run_sweep("reinit");
        step();
        set_ra(0, 5'd3);
        set_ra(1, 5'd4);
        push_rd("post_rst_r3", 0, 32'h0, 1'b0);
        push_rd("post_rst_r4", 1, 32'h0, 1'b0);
        step();
        set_ra(0, 5'd5);
        set_ra(1, 5'd9);
        push_rd("post_rst_r5", 0, 32'h0, 1'b0);
        push_rd("post_rst_r9", 1, 32'h0, 1'b0);

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/core_id_regfile_sb.md
# core_id_regfile_sb

Parametrised register file with scoreboard for the ring-network core's ID stage. It provides NUM_RD combinational read ports with same-cycle write bypass and two write ports: pipeline write-back and ring/memory load return. A per-register pending bit tracks long-latency loads in flight so the ID stage can stall. A post-reset init sweep zeroes the array in hardware, so the core does not depend on software initialisation.

## Interface
Parameters:
- DATA_W, 32, register width
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- NUM_RD, 2, number of read ports

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, synchronous, active-low
- init_done  out  1  high once the array is zeroed; gates all inputs
- raddr  in  NUM_RD*ADDR_W  read addresses, port i at bits [i*ADDR_W +: ADDR_W]
- rdata  out  NUM_RD*DATA_W  read data, port i at bits [i*DATA_W +: DATA_W]
- rbusy  out  NUM_RD  pending flag of each read address
- wen0 / waddr0 / wdata0  in  1 / ADDR_W / DATA_W  pipeline write-back port
- wen1 / waddr1 / wdata1  in  1 / ADDR_W / DATA_W  load-return port; clears pending
- set_pend / pend_addr  in  1 / ADDR_W  mark a register pending at load issue

## Operation
- FSM states: RST, INIT, RUN.
  - While rst=0: state RST; sweep counter = 0; init_done = 0.
  - First edge with rst=1: enter INIT. Each cycle writes reg[cnt] = 0 and pend[cnt] = 0, then increments cnt.
  - After the edge that writes index DEPTH-1: enter RUN, init_done = 1.
  - rst=0 in any state returns to RST on the next edge. Init restarts from index 0.
- In RST and INIT:
  - wen0, wen1 and set_pend are ignored.
  - rdata = 0 and rbusy = 0 on all ports.
- Register 0:
  - Reads always return 0, with rbusy = 0.
  - Writes to it and set_pend on it are ignored.
- Writes in RUN:
  - Both ports to the same address in one cycle: wdata0 is stored.
  - Any write (wen0 or wen1) to address a clears pend[a].
- set_pend sets pend[pend_addr]. If a write to the same address happens in the same cycle, set wins: the data is stored and pend stays 1.
- Read bypass, per port, in this priority:
  1. raddr = 0 → 0
  2. wen0 && waddr0 = raddr → wdata0
  3. wen1 && waddr1 = raddr → wdata1
  4. otherwise reg[raddr]
- rbusy shows the post-edge view of the pending bit:
  - 1 if set_pend && pend_addr = raddr
  - else 0 if written this cycle
  - else pend[raddr]

## Timing
- Reads and rbusy: combinational, zero latency.
- Writes and pending updates: visible in storage after the next rising edge; visible on the read ports in the same cycle via bypass.
- Init sweep: exactly DEPTH cycles after rst rises. With the defaults, init_done rises at the 32nd edge after rst=1 is sampled.
- Reset values: init_done = 0, state = RST, cnt = 0. rdata and rbusy are 0 throughout reset and init.

## Structure
- Package core_rf_pkg holds:
  - default DATA_W / ADDR_W / NUM_RD
  - state enum (RST, INIT, RUN)
  - the zero-register address constant
- Sub-module core_rf_rd_port, instanced NUM_RD times through generate. It takes the address, both write ports, set_pend, array data and pending bit, and produces rdata and rbusy with the bypass priority above.
- The top level holds the array, pend vector, FSM and sweep counter.

## Test plan
- Reset/init:
  - Hold rst=0 for 3 cycles, release. init_done = 0 for 32 cycles, then 1.
  - All 32 registers read 0 with rbusy = 0.
  - A wen0 issued during INIT is dropped.
- Basic write/read:
  - wen0 writes reg5 = 0xDEADBEEF. The same cycle, raddr port0 = 5 returns 0xDEADBEEF via bypass.
  - The next cycle it returns the same value from the array.
- Dual write collision:
  - wen0 reg7 = 0x11 and wen1 reg7 = 0x22 in the same cycle. The read bypass returns 0x11 and reg7 holds 0x11.
  - pend[7] is cleared.
- Scoreboard:
  - set_pend reg9. rbusy = 1 the same cycle and every cycle after.
  - wen1 reg9 = 0x55: rbusy = 0 and rdata = 0x55 that cycle.
  - The same-cycle set_pend + wen1 on reg9 leaves rbusy = 1.
- Register 0: wen0 reg0 = 0xFFFFFFFF plus set_pend reg0. Reads return 0 with rbusy = 0.
- Mid-run reset: write reg3 = 0x1234 and set pend on reg4, then pulse rst=0 for 1 cycle. After the re-init (32 cycles), reg3 reads 0, rbusy on reg4 = 0, and init_done is low during the sweep.
